// File: rtl/alu_mc_if.sv
// -----------------------------------------------------------------------------
// alu_mc_if
// Groups the operand, command and result signals of the multi-cycle ALU.
// Clock and reset are not part of this bundle; they are plain ports on the
// design.
//
// Signals:
//   A, B      operands (B[log2(WIDTH)-1:0] is the shift amount)
//   ALUOp     4-bit operation select
//   start     launches MULT/MULTU/DIV/DIVU, sampled on the rising clock edge
//   C         combinational result
//   Zero      C == 0
//   Overflow  signed overflow of ADD/SUB
//   busy      iterative operation in progress
//   done      one-cycle pulse: hi/lo have just been written
//   hi, lo    product high/low half, or remainder/quotient
//
// Modports:
//   master  drives operands and command (CPU datapath / testbench side)
//   slave   the ALU itself
// -----------------------------------------------------------------------------
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUOp;
  logic             start;
  logic [WIDTH-1:0] C;
  logic             Zero;
  logic             Overflow;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output A, B, ALUOp, start,
    input  C, Zero, Overflow, busy, done, hi, lo
  );

  modport slave (
    input  A, B, ALUOp, start,
    output C, Zero, Overflow, busy, done, hi, lo
  );
endinterface

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc
// Parametrised multi-cycle ALU for the multi-cycle CPU datapath.
//
// Ops 0-11 are purely combinational on A, B and ALUOp. Ops 12-15 run an
// iterative unit, one step per clock, that needs WIDTH cycles and then
// writes the internal hi/lo registers; C shows lo for those op codes.
//
//   ALUOp: 0 NOP  1 ADD  2 SUB  3 AND  4 OR  5 SLT  6 SLTU  7 XOR  8 NOR
//          9 SLL 10 SRL 11 SRA 12 MULT 13 MULTU 14 DIV 15 DIVU
//
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset (clears FSM, counter, hi, lo, done)
//   bus   alu_mc_if.slave: A, B, ALUOp, start in; C, Zero, Overflow, busy,
//         done, hi, lo out
//
// Configuration macro:
//   ALU_DIV_EN  defined: DIV/DIVU are implemented.
//               undefined: the divider datapath is omitted and start with
//               ALUOp 14/15 is ignored (no busy, no done, hi/lo unchanged).
//
// Parameter:
//   WIDTH  operand/result width, a power of two, at least 8.
// -----------------------------------------------------------------------------
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rstn,
  alu_mc_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_SLT   = 4'd5,
    OP_SLTU  = 4'd6,
    OP_XOR   = 4'd7,
    OP_NOR   = 4'd8,
    OP_SLL   = 4'd9,
    OP_SRL   = 4'd10,
    OP_SRA   = 4'd11,
    OP_MULT  = 4'd12,
    OP_MULTU = 4'd13,
    OP_DIV   = 4'd14,
    OP_DIVU  = 4'd15
  } op_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  op_t op;
  assign op = op_t'(bus.ALUOp);

  // ---------------------------------------------------------------------------
  // Combinational ALU
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] c_res;
  logic             ovf;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;

  assign sum = bus.A + bus.B;
  assign dif = bus.A - bus.B;
  assign sh  = bus.B[SHW-1:0];

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    c_res = bus.A;
    ovf   = 1'b0;
    case (op)
      OP_NOP: c_res = bus.A;
      OP_ADD: begin
        c_res = sum;
        // Operands agree in sign but the sum does not.
        ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        c_res = dif;
        // Operands differ in sign and the result's sign differs from A.
        ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (dif[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_AND:  c_res = bus.A & bus.B;
      OP_OR:   c_res = bus.A | bus.B;
      OP_SLT:  c_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SLTU: c_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      OP_XOR:  c_res = bus.A ^ bus.B;
      OP_NOR:  c_res = ~(bus.A | bus.B);
      OP_SLL:  c_res = bus.A << sh;
      OP_SRL:  c_res = bus.A >> sh;
      OP_SRA:  c_res = $unsigned($signed(bus.A) >>> sh);
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: c_res = lo_q;
      default: c_res = bus.A;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Launch decode
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_nxt;
  logic [SHW-1:0]   cnt;
  logic             last_step;
  logic             launch;
  logic             is_mul;
  logic             is_div;
  logic             sgn_op;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef ALU_DIV_EN
  assign is_div = (op == OP_DIV) || (op == OP_DIVU);
`else
  assign is_div = 1'b0;
`endif
  assign launch = (state == IDLE) && bus.start && (is_mul || is_div);

  // Signed ops iterate on magnitudes; the signs are re-applied at the end.
  assign sgn_op = (op == OP_MULT) || (op == OP_DIV);
  assign sa     = sgn_op & bus.A[WIDTH-1];
  assign sb     = sgn_op & bus.B[WIDTH-1];
  assign a_mag  = sa ? -bus.A : bus.A;
  assign b_mag  = sb ? -bus.B : bus.B;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: clocked blocks use non-blocking assignments so every register
  // samples values from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        cnt <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    last_step = 1'b0;
    case (state)
      IDLE: if (launch) state_nxt = IDLE == IDLE ? RUN : IDLE;
      RUN: begin
        if (cnt == SHW'(WIDTH - 1)) begin
          state_nxt = IDLE;
          last_step = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative datapath
  // acc/mq form a 2*WIDTH shift pair. Multiply: acc is the partial product,
  // mq the multiplier, shifted right once per step. Divide: acc is the
  // partial remainder, mq the dividend shifting out / quotient shifting in.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] opnd;
  logic             neg_q;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mq_nxt;
  logic [WIDTH:0]   mul_sum;
`ifdef ALU_DIV_EN
  logic             run_div;
  logic             neg_rem;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
`endif

  // NOTE: the working registers are fully loaded on every launch and only
  // read while in RUN, so they carry no reset.
  always_ff @(posedge clk) begin
    if (launch) begin
      acc   <= '0;
      mq    <= a_mag;
      opnd  <= b_mag;
      neg_q <= sa ^ sb;
`ifdef ALU_DIV_EN
      run_div <= is_div;
      neg_rem <= sa;
      a_raw   <= bus.A;
`endif
    end else if (state == RUN) begin
      acc <= acc_nxt;
      mq  <= mq_nxt;
    end
  end

  // Shift-add step: add the multiplicand when the multiplier LSB is set,
  // then shift the {carry, acc, mq} chain right by one.
  assign mul_sum = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

`ifdef ALU_DIV_EN
  // Restoring step: bring the next dividend bit into the remainder and keep
  // the difference only when it did not borrow.
  assign div_shift = {acc, mq[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_ok    = ~div_diff[WIDTH];
`endif

  always_comb begin
    acc_nxt = mul_sum[WIDTH:1];
    mq_nxt  = {mul_sum[0], mq[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    if (run_div) begin
      acc_nxt = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      mq_nxt  = {mq[WIDTH-2:0], div_ok};
    end
`endif
  end

  // Final result: the last step feeds straight into hi/lo with signs fixed,
  // so hi/lo update on the same edge that ends RUN.
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   hi_nxt;
  logic [WIDTH-1:0]   lo_nxt;

  assign prod = {acc_nxt, mq_nxt};

  always_comb begin
    prod_fix = neg_q ? -prod : prod;
    hi_nxt   = prod_fix[2*WIDTH-1:WIDTH];
    lo_nxt   = prod_fix[WIDTH-1:0];
`ifdef ALU_DIV_EN
    if (run_div) begin
      if (opnd == '0) begin
        // Divide by zero: no trap, quotient all ones, remainder is A.
        hi_nxt = a_raw;
        lo_nxt = '1;
      end else begin
        // Most-negative / -1 falls out naturally: the magnitude quotient
        // 2^(WIDTH-1) negates back to itself.
        lo_nxt = neg_q   ? -mq_nxt  : mq_nxt;
        hi_nxt = neg_rem ? -acc_nxt : acc_nxt;
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Architectural result registers
  // ---------------------------------------------------------------------------
  logic done_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_step;
      if (last_step) begin
        hi_q <= hi_nxt;
        lo_q <= lo_nxt;
      end
    end
  end

  assign bus.C        = c_res;
  assign bus.Zero     = (c_res == '0);
  assign bus.Overflow = ovf;
  assign bus.busy     = (state == RUN);
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule
